dcache_dm: RTL

//  Parametrised direct-mapped, write-through, no-write-allocate data cache for the pipelined core.

---
 rtl/dcache_dm_pkg.sv | 33 +++
 rtl/dcache_dm_align.sv | 36 +++
 rtl/dcache_dm.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_dm_pkg.sv
// rtl/dcache_dm_pkg.sv - shared width codes, FSM states and lane helpers for dcache_dm
package dcache_dm_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RESP   = 2'd1,
      S_REFILL = 2'd2,
      S_WRITE  = 2'd3
   } state_e;

   function automatic logic [3:0] lane_strobe(input logic [1:0] width, input logic [1:0] off);
      case (width)
         W_BYTE:  lane_strobe = 4'b0001 << off;
         W_HALF:  lane_strobe = off[1] ? 4'b1100 : 4'b0011;
         W_WORD:  lane_strobe = 4'b1111;
         default: lane_strobe = 4'b0000;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
      case (width)
         W_BYTE:  is_misaligned = 1'b0;
         W_HALF:  is_misaligned = off[0];
         W_WORD:  is_misaligned = (off != 2'b00);
         default: is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dcache_dm_align.sv
// rtl/dcache_dm_align.sv - load extract/extend and store lane/strobe generation
module dcache_dm_align import dcache_dm_pkg::*; (
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  width_i,
   input  logic        zext_i,
   input  logic [31:0] sdata_i,
   output logic        misalign_o,
   output logic [31:0] load_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted    = word_i >> {off_i, 3'b000};
      misalign_o = is_misaligned(width_i, off_i);
      wstrb_o    = lane_strobe(width_i, off_i);
      case (width_i)
         W_BYTE: begin
            load_o  = zext_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            wdata_o = {4{sdata_i[7:0]}};
         end
         W_HALF: begin
            load_o  = zext_i ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            wdata_o = {2{sdata_i[15:0]}};
         end
         default: begin
            load_o  = shifted;
            wdata_o = sdata_i;
         end
      endcase
   end

endmodule

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through no-write-allocate data cache
module dcache_dm import dcache_dm_pkg::*; #(
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        w_ena,
   input  logic [31:0] addr,
   input  logic [1:0]  width,
   input  logic        zext,
   input  logic [31:0] data_in,
   input  logic        inv,
   output logic        valid,
   output logic        misalign,
   output logic [31:0] data_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int OFF_W = $clog2(LINE_WORDS) + 2;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - IDX_W - OFF_W;
   localparam int DI_W  = IDX_W + OFF_W - 2;
   localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d, sdata_q, sdata_d, dout_q, dout_d;
   logic [1:0]       width_q, width_d;
   logic             zext_q, zext_d, hit_q, hit_d, mis_q, mis_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SETS-1:0]  line_vld_q, line_vld_d;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS*LINE_WORDS];

   logic             idle, lookup_hit, refill_last, crit_now;
   logic [IDX_W-1:0] in_idx, cur_idx;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      line_base, refill_addr, al_word, al_load, al_wdata;
   logic [3:0]       al_wstrb;
   logic             al_mis;

   assign idle        = (state_q == S_IDLE);
   assign in_idx      = addr[IDX_W+OFF_W-1:OFF_W];
   assign in_tag      = addr[31:IDX_W+OFF_W];
   assign cur_idx     = addr_q[IDX_W+OFF_W-1:OFF_W];
   // A concurrent inv makes the lookup see the already-cleared valid bits.
   assign lookup_hit  = line_vld_q[in_idx] && !inv && (tag_q[in_idx] == in_tag);
   assign line_base   = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
   assign refill_addr = line_base | (32'(cnt_q) << 2);
   assign refill_last = (32'(cnt_q) == 32'(LINE_WORDS - 1));
   assign crit_now    = (addr_q[DI_W+1:2] == refill_addr[DI_W+1:2]);

   // The requested word may arrive on the final ack, before it lands in the array.
   assign al_word = idle     ? data_q[addr[DI_W+1:2]] :
                    crit_now ? mem_rdata : data_q[addr_q[DI_W+1:2]];

   dcache_dm_align u_align (
      .word_i     (al_word),
      .off_i      (idle ? addr[1:0] : addr_q[1:0]),
      .width_i    (idle ? width : width_q),
      .zext_i     (idle ? zext : zext_q),
      .sdata_i    (idle ? data_in : sdata_q),
      .misalign_o (al_mis),
      .load_o     (al_load),
      .wdata_o    (al_wdata),
      .wstrb_o    (al_wstrb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      width_d    = width_q;
      zext_d     = zext_q;
      hit_d      = hit_q;
      mis_d      = mis_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      line_vld_d = line_vld_q;
      if (idle && inv) line_vld_d = '0;
      case (state_q)
         S_IDLE: if (req) begin
            addr_d  = addr;
            width_d = width;
            zext_d  = zext;
            sdata_d = data_in;
            mis_d   = al_mis;
            hit_d   = lookup_hit;
            cnt_d   = '0;
            if (al_mis) begin
               state_d = S_RESP;
               dout_d  = '0;
            end else if (w_ena) begin
               state_d = S_WRITE;
            end else if (lookup_hit) begin
               state_d = S_RESP;
               dout_d  = al_load;
            end else begin
               state_d            = S_REFILL;
               line_vld_d[in_idx] = 1'b0;
            end
         end
         S_REFILL: if (mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (refill_last) begin
               line_vld_d[cur_idx] = 1'b1;
               dout_d              = al_load;
               state_d             = S_RESP;
            end
         end
         S_WRITE: if (mem_ack) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid     = 1'b0;
      misalign  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      case (state_q)
         S_RESP: begin
            valid    = 1'b1;
            misalign = mis_q;
         end
         S_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = refill_addr;
         end
         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = al_wdata;
            mem_wstrb = al_wstrb;
         end
         default: ;
      endcase
   end

   assign data_out = dout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         sdata_q    <= '0;
         dout_q     <= '0;
         width_q    <= '0;
         zext_q     <= 1'b0;
         hit_q      <= 1'b0;
         mis_q      <= 1'b0;
         cnt_q      <= '0;
         line_vld_q <= '0;
      end else begin
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         dout_q     <= dout_d;
         width_q    <= width_d;
         zext_q     <= zext_d;
         hit_q      <= hit_d;
         mis_q      <= mis_d;
         cnt_q      <= cnt_d;
         line_vld_q <= line_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_REFILL && mem_ack) begin
         data_q[refill_addr[DI_W+1:2]] <= mem_rdata;
         if (refill_last) tag_q[cur_idx] <= addr_q[31:IDX_W+OFF_W];
      end
      if (state_q == S_WRITE && mem_ack && hit_q) begin
         for (int b = 0; b < 4; b++)
            if (al_wstrb[b]) data_q[addr_q[DI_W+1:2]][8*b +: 8] <= al_wdata[8*b +: 8];
      end
   end

endmodule
